if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register for the five-stage MIPS datapath. It captures the fetched instruction and PC on every clock and holds them when the hazard unit stalls. On a flush request it injects NOP bubbles for a programmable number of cycles, which covers branches resolved in ID (1 bubble) or later stages (2–4 bubbles). It replaces the combinational instruction-zeroing path between IF and ID with a registered stage that carries a valid bit.

---
 rtl/if_id_pipe_reg.sv | 65 ++++++
 tb/tb_if_id_pipe_reg.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with stall hold and multi-cycle flush bubbles
module if_id_pipe_reg #(
    parameter int                 INST_W      = 32,
    parameter int                 PC_W        = 32,
    parameter logic [INST_W-1:0]  NOP_INST    = '0,
    parameter int                 FLUSH_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] IF_Inst,
    input  logic [PC_W-1:0]   IF_PC,
    input  logic              Stall,
    input  logic              Flush,
    output logic [INST_W-1:0] ID_Inst,
    output logic [PC_W-1:0]   ID_PC,
    output logic              ID_Valid,
    output logic              Flush_Busy
);
    localparam logic [1:0] CNT_LOAD = 2'(FLUSH_DEPTH - 1);

    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 4) begin : g_bad_depth
        $error("if_id_pipe_reg: FLUSH_DEPTH=%0d outside 1..4", FLUSH_DEPTH);
    end

    logic [INST_W-1:0] inst_d, inst_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic              valid_d, valid_q;
    logic [1:0]        cnt_d, cnt_q;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (Flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            cnt_d   = CNT_LOAD;
        end else if (!Stall) begin
            inst_d  = (cnt_q != 2'd0) ? NOP_INST : IF_Inst;
            pc_d    = (cnt_q != 2'd0) ? pc_q : IF_PC;
            valid_d = (cnt_q == 2'd0);
            cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ID_Inst    = inst_q;
    assign ID_PC      = pc_q;
    assign ID_Valid   = valid_q;
    assign Flush_Busy = (cnt_q != 2'd0);
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: three depths (1,3,4) driven in parallel, checked against a bubble-counting model
module tb_if_id_pipe_reg;
    logic        clk = 1'b0;
    logic        rst, Stall, Flush;
    logic [31:0] IF_Inst, IF_PC;
    logic [31:0] o_inst [3];
    logic [31:0] o_pc   [3];
    logic        o_v    [3];
    logic        o_busy [3];

    int          depth [3] = '{1, 3, 4};
    logic [31:0] m_inst [3];
    logic [31:0] m_pc   [3];
    bit          m_v    [3];
    int          m_left [3];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    if_id_pipe_reg #(.FLUSH_DEPTH(1)) d1 (.clk(clk), .rst(rst), .IF_Inst(IF_Inst), .IF_PC(IF_PC),
        .Stall(Stall), .Flush(Flush), .ID_Inst(o_inst[0]), .ID_PC(o_pc[0]), .ID_Valid(o_v[0]),
        .Flush_Busy(o_busy[0]));
    if_id_pipe_reg #(.FLUSH_DEPTH(3)) d3 (.clk(clk), .rst(rst), .IF_Inst(IF_Inst), .IF_PC(IF_PC),
        .Stall(Stall), .Flush(Flush), .ID_Inst(o_inst[1]), .ID_PC(o_pc[1]), .ID_Valid(o_v[1]),
        .Flush_Busy(o_busy[1]));
    if_id_pipe_reg #(.FLUSH_DEPTH(4)) d4 (.clk(clk), .rst(rst), .IF_Inst(IF_Inst), .IF_PC(IF_PC),
        .Stall(Stall), .Flush(Flush), .ID_Inst(o_inst[2]), .ID_PC(o_pc[2]), .ID_Valid(o_v[2]),
        .Flush_Busy(o_busy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model tracks how many bubbles remain after the current one; depth D flush leaves D-1 pending.
    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] ins, input logic [31:0] pc);
        rst = r; Stall = s; Flush = f; IF_Inst = ins; IF_PC = pc;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_inst[i] = 32'h0; m_pc[i] = 32'h0; m_v[i] = 0; m_left[i] = 0;
            end else if (f) begin
                m_inst[i] = 32'h0; m_v[i] = 0; m_left[i] = depth[i] - 1;
            end else if (!s) begin
                if (m_left[i] > 0) begin
                    m_inst[i] = 32'h0; m_v[i] = 0; m_left[i]--;
                end else begin
                    m_inst[i] = ins; m_pc[i] = pc; m_v[i] = 1;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_inst", depth[i]), o_inst[i], m_inst[i]);
            chk($sformatf("d%0d_pc", depth[i]), o_pc[i], m_pc[i]);
            chk($sformatf("d%0d_valid", depth[i]), 32'(o_v[i]), 32'(m_v[i]));
            chk($sformatf("d%0d_busy", depth[i]), 32'(o_busy[i]), 32'(m_left[i] != 0));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, $urandom, $urandom);
    endtask

    initial begin
        int n;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            m_inst[i] = 0; m_pc[i] = 0; m_v[i] = 0; m_left[i] = 0;
        end
        step(1, 0, 0, 32'h2008_0005, 32'h4);
        step(1, 0, 0, 32'h2008_0005, 32'h4);
        chk("rst_inst", o_inst[0], 32'h0);
        chk("rst_valid", 32'(o_v[0]), 32'h0);
        step(0, 0, 0, 32'h2008_0005, 32'h4);
        chk("free_inst", o_inst[0], 32'h2008_0005);
        chk("free_pc", o_pc[0], 32'h4);
        chk("free_valid", 32'(o_v[0]), 32'h1);
        step(0, 0, 0, 32'h8C09_0000, 32'h8);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h0128_5020, 32'hC);
            chk("stall_inst", o_inst[0], 32'h8C09_0000);
            chk("stall_valid", 32'(o_v[0]), 32'h1);
        end
        step(0, 0, 0, 32'h0128_5020, 32'hC);
        chk("unstall_inst", o_inst[0], 32'h0128_5020);
        step(0, 1, 1, 32'hDEAD_BEEF, 32'h10);
        chk("fs_inst", o_inst[0], 32'h0);
        chk("fs_valid", 32'(o_v[0]), 32'h0);
        chk("fs_pc", o_pc[0], 32'hC);
        step(0, 0, 0, 32'h1111_1111, 32'h14);
        chk("fs_capture", o_inst[0], 32'h1111_1111);
        idle(5);
        step(0, 0, 1, $urandom, $urandom);
        chk("d3_n_busy", 32'(o_busy[1]), 32'h1);
        idle(1);
        chk("d3_n1_busy", 32'(o_busy[1]), 32'h1);
        chk("d3_n1_valid", 32'(o_v[1]), 32'h0);
        idle(1);
        chk("d3_n2_busy", 32'(o_busy[1]), 32'h0);
        chk("d3_n2_valid", 32'(o_v[1]), 32'h0);
        idle(1);
        chk("d3_n3_valid", 32'(o_v[1]), 32'h1);
        idle(3);
        step(0, 0, 1, $urandom, $urandom);
        step(0, 1, 0, $urandom, $urandom);
        idle(2);
        chk("d3_stall_n3", 32'(o_v[1]), 32'h0);
        idle(1);
        chk("d3_stall_n4", 32'(o_v[1]), 32'h1);
        idle(5);
        step(0, 0, 1, $urandom, $urandom);
        idle(1);
        step(0, 0, 1, $urandom, $urandom);
        n = 1;
        for (int k = 0; k < 10 && !o_v[2]; k++) begin
            idle(1);
            if (!o_v[2]) n++;
        end
        chk("d4_reload_bubbles", 32'(n), 32'd4);
        chk("d4_reload_capture", 32'(o_v[2]), 32'h1);
        idle(5);
        step(0, 0, 1, $urandom, $urandom);
        step(1, 0, 0, $urandom, $urandom);
        chk("d4_rst_busy", 32'(o_busy[2]), 32'h0);
        r = $urandom;
        step(0, 0, 0, r, 32'h40);
        chk("d4_rst_capture", o_inst[2], r);
        chk("d4_rst_valid", 32'(o_v[2]), 32'h1);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom, $urandom);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
